// File: rtl/hilo_mult_sequencer_if.sv
// Issue/response bundle between the pipeline and the HI/LO multiply sequencer.
interface hilo_mult_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              Start;
    logic [2:0]        Op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              MfRead;
    logic              Busy;
    logic              Stall;
    logic              Done;
    logic [DATA_W-1:0] HiOUT;
    logic [DATA_W-1:0] LoOUT;

    modport master (
        output Start, Op, A, B, MfRead,
        input  Busy, Stall, Done, HiOUT, LoOUT
    );

    modport slave (
        input  Start, Op, A, B, MfRead,
        output Busy, Stall, Done, HiOUT, LoOUT
    );
endinterface

// File: rtl/hilo_mult_sequencer.sv
// Iterative radix-2 multiply/accumulate unit owning the architectural HI/LO pair.
module hilo_mult_sequencer #(
    parameter int DATA_W = 32
) (
    input logic                 Clk,
    input logic                 Rst,
    hilo_mult_sequencer_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [5:0] CNT_LAST = 6'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

    state_t                     state, state_nxt;
    logic                       mul_go, mthi_go, mtlo_go, acc_go;
    logic                       signed_op;
    logic [5:0]                 cnt;
    logic [2:0]                 op_q;
    logic                       neg_q;
    logic [2*DATA_W-1:0]        mcand;
    logic [DATA_W-1:0]          mplier;
    logic [2*DATA_W-1:0]        prod;
    logic [DATA_W-1:0]          hi_q, lo_q;
    logic signed [DATA_W-1:0]   a_s, b_s;

    // Magnitude of a two's-complement operand; the most negative value maps to 2^(W-1).
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        if (is_signed && v < 0)
            return $unsigned(-v);
        return $unsigned(v);
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] mag,
                                                       input logic neg);
        return neg ? -mag : mag;
    endfunction

    // Final HI/LO value; MADD/MSUB wrap modulo 2^(2W).
    function automatic logic [2*DATA_W-1:0] accumulate(input logic [2:0] op,
                                                       input logic [2*DATA_W-1:0] hilo,
                                                       input logic [2*DATA_W-1:0] p);
        case (op)
            OP_MADD: return hilo + p;
            OP_MSUB: return hilo - p;
            default: return p;
        endcase
    endfunction

    assign a_s       = bus.A;
    assign b_s       = bus.B;
    assign signed_op = (bus.Op != OP_MULTU);

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_go    = 1'b0;
        mthi_go   = 1'b0;
        mtlo_go   = 1'b0;
        acc_go    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Op[2] == 1'b0) begin
                        mul_go    = 1'b1;
                        state_nxt = MUL;
                    end else if (bus.Op == OP_MTHI) begin
                        mthi_go = 1'b1;
                    end else if (bus.Op == OP_MTLO) begin
                        mtlo_go = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt == CNT_LAST)
                    state_nxt = ACC;
            end
            ACC: begin
                acc_go    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            op_q     <= OP_MULT;
            neg_q    <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            bus.Done <= 1'b0;
        end else begin
            bus.Done <= acc_go | mthi_go | mtlo_go;
            // Operands latched as magnitudes; the sign is folded back in at ACC.
            if (mul_go) begin
                mcand  <= {{DATA_W{1'b0}}, magnitude(a_s, signed_op)};
                mplier <= magnitude(b_s, signed_op);
                prod   <= '0;
                op_q   <= bus.Op;
                neg_q  <= signed_op & (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
                cnt    <= '0;
            end else if (state == MUL) begin
                if (mplier[0])
                    prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 6'd1;
            end
            if (acc_go)
                {hi_q, lo_q} <= accumulate(op_q, {hi_q, lo_q}, apply_sign(prod, neg_q));
            if (mthi_go)
                hi_q <= bus.A;
            if (mtlo_go)
                lo_q <= bus.A;
        end
    end

    assign bus.Busy  = (state != IDLE);
    assign bus.Stall = bus.Busy & (bus.Start | bus.MfRead);
    assign bus.HiOUT = hi_q;
    assign bus.LoOUT = lo_q;
endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for the HI/LO multiply sequencer.
module tb_hilo_mult_sequencer;
    logic Clk;
    logic Rst;
    int   checks = 0;
    int   errors = 0;
    int   busy_n, early_done, lo_hits, done_n;

    hilo_mult_sequencer_if bus ();

    hilo_mult_sequencer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request at the next edge, then scramble operands.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.Start = 1'b0;
        bus.Op    = 3'b110;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'h8000_0001;
    endtask

    // Advance until Busy drops, with a hard cycle bound.
    task automatic wait_idle(output int busy_cycles, output int done_in_busy, output int lo_1234);
        int n;
        busy_cycles  = 0;
        done_in_busy = 0;
        lo_1234      = 0;
        n            = 0;
        while (bus.Busy && n < 60) begin
            busy_cycles++;
            if (bus.Done) done_in_busy++;
            if (bus.LoOUT == 32'h0000_1234) lo_1234++;
            tick();
            n++;
        end
        chk("busy_bounded", {63'd0, bus.Busy}, 64'd0);
    endtask

    initial begin
        Rst        = 1'b1;
        bus.Start  = 1'b0;
        bus.Op     = 3'b000;
        bus.A      = '0;
        bus.B      = '0;
        bus.MfRead = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
        chk("rst_done", {63'd0, bus.Done}, 64'd0);
        chk("rst_hilo", {bus.HiOUT, bus.LoOUT}, 64'd0);
        bus.MfRead = 1'b1;
        #1;
        chk("rst_stall_mfread", {63'd0, bus.Stall}, 64'd0);
        bus.MfRead = 1'b0;

        // MULT -3 * 7
        issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_idle(busy_n, early_done, lo_hits);
        chk("mult_busy_cycles", 64'(busy_n), 64'd33);
        chk("mult_no_early_done", 64'(early_done), 64'd0);
        chk("mult_done", {63'd0, bus.Done}, 64'd1);
        chk("mult_hilo", {bus.HiOUT, bus.LoOUT}, 64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        chk("mult_done_once", {63'd0, bus.Done}, 64'd0);

        // MULTU max * max
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(busy_n, early_done, lo_hits);
        chk("multu_busy_cycles", 64'(busy_n), 64'd33);
        chk("multu_hilo", {bus.HiOUT, bus.LoOUT}, 64'hFFFF_FFFE_0000_0001);
        tick();

        // MTHI / MTLO / MADD / MSUB chain
        issue(3'b100, 32'h0000_0000, 32'h0);
        chk("mthi_busy", {63'd0, bus.Busy}, 64'd0);
        chk("mthi_done", {63'd0, bus.Done}, 64'd1);
        chk("mthi_hi", {32'd0, bus.HiOUT}, 64'd0);
        issue(3'b101, 32'h0000_0005, 32'h0);
        chk("mtlo_busy", {63'd0, bus.Busy}, 64'd0);
        chk("mtlo_done", {63'd0, bus.Done}, 64'd1);
        chk("mtlo_hilo", {bus.HiOUT, bus.LoOUT}, 64'h0000_0000_0000_0005);
        tick();
        chk("mtlo_done_once", {63'd0, bus.Done}, 64'd0);
        issue(3'b010, 32'd2, 32'd3);
        wait_idle(busy_n, early_done, lo_hits);
        chk("madd_hilo", {bus.HiOUT, bus.LoOUT}, 64'h0000_0000_0000_000B);
        chk("madd_done", {63'd0, bus.Done}, 64'd1);
        tick();
        issue(3'b011, 32'd4, 32'd4);
        wait_idle(busy_n, early_done, lo_hits);
        chk("msub_hilo", {bus.HiOUT, bus.LoOUT}, 64'hFFFF_FFFF_FFFF_FFFB);
        tick();

        // Second Start (MTLO) at E10 of MULT 6*7 must be ignored
        issue(3'b000, 32'd6, 32'd7);
        repeat (9) tick();
        bus.Start = 1'b1;
        bus.Op    = 3'b101;
        bus.A     = 32'h0000_1234;
        #1;
        chk("start_while_busy_stall", {63'd0, bus.Stall}, 64'd1);
        tick();
        bus.Start = 1'b0;
        chk("start_while_busy_lo", {32'd0, bus.LoOUT}, 64'hFFFF_FFFB);
        wait_idle(busy_n, early_done, lo_hits);
        chk("ignored_start_no_done", 64'(early_done), 64'd0);
        chk("ignored_start_lo_never", 64'(lo_hits), 64'd0);
        chk("mult_6x7_hilo", {bus.HiOUT, bus.LoOUT}, 64'h0000_0000_0000_002A);
        tick();

        // MfRead behaviour and Done-cycle stall
        issue(3'b000, 32'd1, 32'd1);
        bus.MfRead = 1'b1;
        #1;
        chk("mfread_busy_stall", {63'd0, bus.Stall}, 64'd1);
        wait_idle(busy_n, early_done, lo_hits);
        chk("done_cycle_done", {63'd0, bus.Done}, 64'd1);
        chk("done_cycle_stall", {63'd0, bus.Stall}, 64'd0);
        chk("mult_1x1_hilo", {bus.HiOUT, bus.LoOUT}, 64'h0000_0000_0000_0001);
        tick();
        chk("mfread_idle_stall", {63'd0, bus.Stall}, 64'd0);
        bus.MfRead = 1'b0;
        issue(3'b111, 32'h7777_7777, 32'd9);
        chk("reserved_busy", {63'd0, bus.Busy}, 64'd0);
        chk("reserved_done", {63'd0, bus.Done}, 64'd0);
        chk("reserved_hilo", {bus.HiOUT, bus.LoOUT}, 64'h0000_0000_0000_0001);
        tick();
        chk("reserved_done_late", {63'd0, bus.Done}, 64'd0);

        // Reset at E12 of a multiply discards it
        issue(3'b100, 32'h0000_0077, 32'd0);
        issue(3'b101, 32'h0000_0055, 32'd0);
        chk("pre_reset_hilo", {bus.HiOUT, bus.LoOUT}, 64'h0000_0077_0000_0055);
        issue(3'b000, 32'd3, 32'd5);
        repeat (11) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("midrst_busy", {63'd0, bus.Busy}, 64'd0);
        chk("midrst_hilo", {bus.HiOUT, bus.LoOUT}, 64'd0);
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done) done_n++;
            if (bus.Busy || bus.Stall) busy_n++;
            tick();
        end
        chk("midrst_no_done", 64'(done_n), 64'd0);
        chk("midrst_stays_idle", 64'(busy_n), 64'd0);
        chk("midrst_hilo_kept", {bus.HiOUT, bus.LoOUT}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
